// File: rtl/burst_seq_ctrl.sv
// burst_seq_ctrl: A -> B x NUM_B -> C sequencer with stall timeout.
// Define BURST_SEQ_SVA_EN to embed handshake assertions.
module burst_seq_ctrl #(
  parameter int NUM_B   = 5,
  parameter int CNT_W   = 4,
  parameter int GAP_MAX = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             b_ready,
  input  logic             abort,
  input  logic             err_clr,
  output logic             b_valid,
  output logic             c_out,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_CSTB  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(NUM_B - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP_MAX - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      b_valid   <= 1'b0;
      c_out     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_BURST;
            b_valid   <= 1'b1;
            busy      <= 1'b1;
            beat_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        S_BURST: begin
          // abort wins over both accept and timeout
          if (abort) begin
            state     <= S_IDLE;
            b_valid   <= 1'b0;
            busy      <= 1'b0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
          end else if (b_ready) begin
            beat_cnt  <= beat_cnt + ONE;
            stall_cnt <= '0;
            if (beat_cnt == B_LAST) begin
              state   <= S_CSTB;
              b_valid <= 1'b0;
              c_out   <= 1'b1;
              done    <= 1'b1;
            end
          end else if (stall_cnt == G_LAST) begin
            state     <= S_ERR;
            b_valid   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b1;
            stall_cnt <= stall_cnt + ONE;
          end else begin
            stall_cnt <= stall_cnt + ONE;
          end
        end
        S_CSTB: begin
          state <= S_IDLE;
          c_out <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        S_ERR: begin
          if (err_clr) begin
            state <= S_IDLE;
            err   <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          b_valid <= 1'b0;
          c_out   <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

`ifdef BURST_SEQ_SVA_EN
  a_start_bv: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_IDLE && start) |=> b_valid)
    else $error("a_start_bv failed at %0t", $time);

  a_last_c: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_BURST && b_valid && b_ready && !abort
     && beat_cnt == B_LAST) |=> c_out)
    else $error("a_last_c failed at %0t", $time);

  a_c_once: assert property (@(posedge clk) disable iff (!rst_n)
    c_out |=> !c_out)
    else $error("a_c_once failed at %0t", $time);

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (b_valid && !b_ready && !abort) |=> (b_valid || err))
    else $error("a_stall_hold failed at %0t", $time);
`endif

endmodule

// File: tb/tb_burst_seq_ctrl.sv
// tb_burst_seq_ctrl: scoreboard bench for burst_seq_ctrl.
// Stimulus queues expected events; a negedge monitor checks them.
module tb_burst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       b_ready = 1'b0;
  logic       abort = 1'b0;
  logic       err_clr = 1'b0;
  logic       b_valid, c_out, done, busy, err;
  logic [3:0] beat_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef enum int {EV_ACC, EV_C, EV_ERR} kind_t;
  typedef struct {
    kind_t kind;
    int    cyc;
    int    beat;
  } ev_t;

  ev_t exp_q[$];
  bit  err_d = 1'b0;

  burst_seq_ctrl #(
    .NUM_B(5),
    .CNT_W(4),
    .GAP_MAX(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .b_ready(b_ready),
    .abort(abort),
    .err_clr(err_clr),
    .b_valid(b_valid),
    .c_out(c_out),
    .done(done),
    .busy(busy),
    .err(err),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp_v, cyc);
    end
  endtask

  task automatic observe(input kind_t k, input int beat);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d beat %0d at cycle %0d, expected none",
               k, beat, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_beat", beat, e.beat);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_valid && b_ready && !abort) begin
        observe(EV_ACC, int'(beat_cnt));
      end else if (c_out) begin
        observe(EV_C, int'(beat_cnt));
        chk("done_with_c", done, 1);
        chk("busy_in_c", busy, 1);
      end
      if (err && !err_d) observe(EV_ERR, int'(beat_cnt));
    end
    err_d = err;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input kind_t k, input int c, input int b);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.beat = b;
    exp_q.push_back(e);
  endtask

  task automatic push_full(input int s);
    for (int i = 0; i < 5; i++) push(EV_ACC, s + 1 + i, i);
    push(EV_C, s + 6, 5);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk({nm, "_missing_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_b_valid"}, b_valid, 0);
    chk({nm, "_c_out"}, c_out, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_beat_cnt"}, int'(beat_cnt), 0);
  endtask

  task automatic burst_full(input string nm);
    int s;
    s = cyc;
    start   = 1'b1;
    b_ready = 1'b1;
    push_full(s);
    step();
    start = 1'b0;
    step(6);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_c_after"}, c_out, 0);
    chk({nm, "_beat_hold"}, int'(beat_cnt), 5);
    b_ready = 1'b0;
    step(2);
    chk({nm, "_beat_hold2"}, int'(beat_cnt), 5);
    drain(nm);
  endtask

  initial begin
    logic [7:0] pat;
    int s;
    pat = 8'b1110_0101;

    #12;
    chk_zero("reset");
    #5 rst_n = 1'b1;
    step(2);

    burst_full("full");

    // b_ready pattern 1,0,1,0,0,1,1,1 (pat[0] first)
    s = cyc;
    start = 1'b1;
    push(EV_ACC, s + 1, 0);
    push(EV_ACC, s + 3, 1);
    push(EV_ACC, s + 6, 2);
    push(EV_ACC, s + 7, 3);
    push(EV_ACC, s + 8, 4);
    push(EV_C, s + 9, 5);
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_ready = pat[i];
      step();
    end
    b_ready = 1'b0;
    step(2);
    chk("pat_err", err, 0);
    chk("pat_beat", int'(beat_cnt), 5);
    chk("pat_busy", busy, 0);
    drain("pattern");

    // stall timeout
    s = cyc;
    start   = 1'b1;
    b_ready = 1'b0;
    push(EV_ERR, s + 13, 0);
    step();
    start = 1'b0;
    step(11);
    chk("stall_pre_err", err, 0);
    chk("stall_pre_bv", b_valid, 1);
    step();
    chk("stall_err", err, 1);
    chk("stall_bv", b_valid, 0);
    chk("stall_busy", busy, 0);
    start = 1'b1;
    step(2);
    start = 1'b0;
    chk("err_start_ign_err", err, 1);
    chk("err_start_ign_bv", b_valid, 0);
    chk("err_start_ign_busy", busy, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_busy", busy, 0);
    drain("stall");
    burst_full("after_clr");

    // abort after 3 accepts, coincident with b_ready
    s = cyc;
    start   = 1'b1;
    b_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(EV_ACC, s + 1 + i, i);
    step();
    start = 1'b0;
    step(3);
    abort = 1'b1;
    step();
    abort   = 1'b0;
    b_ready = 1'b0;
    chk("abort_beat", int'(beat_cnt), 0);
    chk("abort_busy", busy, 0);
    chk("abort_bv", b_valid, 0);
    chk("abort_c", c_out, 0);
    step(8);
    drain("abort");

    // asynchronous reset mid-burst
    s = cyc;
    start   = 1'b1;
    b_ready = 1'b1;
    push(EV_ACC, s + 1, 0);
    push(EV_ACC, s + 2, 1);
    step();
    start = 1'b0;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    b_ready = 1'b0;
    #10 rst_n = 1'b1;
    step();
    drain("async_rst");
    burst_full("after_rst");

    // start held high: one IDLE cycle between bursts, nothing queued
    s = cyc;
    start   = 1'b1;
    b_ready = 1'b1;
    push_full(s);
    push_full(s + 7);
    step(7);
    chk("gap_busy", busy, 0);
    chk("gap_bv", b_valid, 0);
    step(6);
    start = 1'b0;
    step(2);
    chk("held_end_busy", busy, 0);
    step(3);
    chk("held_no_queue_busy", busy, 0);
    chk("held_no_queue_bv", b_valid, 0);
    b_ready = 1'b0;
    drain("held");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
